// File: rtl/drum_sequencer.sv
// Step-pattern drum sequencer: a 16x4 pattern memory, a step timer that fires
// per-instrument go pulses, and a free-running sample-rate tick.
module drum_sequencer #(
    parameter int SAMPLE_DIV = 1042,
    parameter int MIN_PERIOD = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic [23:0] step_period,
    input  logic [3:0]  mute,
    input  logic        pattern_we,
    input  logic [3:0]  pattern_addr,
    input  logic [3:0]  pattern_wdata,
    output logic [3:0]  go,
    output logic        en,
    output logic [3:0]  step,
    output logic        playing
);

    localparam int              DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [23:0]     MIN_P    = 24'(MIN_PERIOD);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      scnt_q, scnt_d;
    logic [23:0]      per_q, per_d;
    logic [23:0]      per_in;
    logic [3:0]       step_d, step_nxt;
    logic [3:0]       go_d;
    logic             playing_d;
    logic [3:0]       mem [16];
    logic [DIV_W-1:0] div_q;

    // Periods below the minimum are clamped so a go bit can never stay high
    // across two consecutive cycles.
    assign per_in   = (step_period < MIN_P) ? MIN_P : step_period;
    assign step_nxt = step + 4'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        scnt_d    = scnt_q;
        per_d     = per_q;
        step_d    = step;
        go_d      = '0;
        playing_d = playing;

        case (state_q)
            IDLE: begin
                scnt_d    = '0;
                playing_d = 1'b0;
                if (run) begin
                    state_d   = PLAY;
                    step_d    = '0;
                    per_d     = per_in;
                    go_d      = mem[0] & ~mute;
                    playing_d = 1'b1;
                end
            end
            PLAY: begin
                // Stop wins over a coinciding step boundary.
                if (!run) begin
                    state_d   = IDLE;
                    step_d    = '0;
                    scnt_d    = '0;
                    playing_d = 1'b0;
                end else if (scnt_q == per_q - 24'd1) begin
                    scnt_d = '0;
                    step_d = step_nxt;
                    go_d   = mem[step_nxt] & ~mute;
                    per_d  = per_in;
                end else begin
                    scnt_d = scnt_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            per_q   <= '0;
            step    <= '0;
            go      <= '0;
            playing <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            per_q   <= per_d;
            step    <= step_d;
            go      <= go_d;
            playing <= playing_d;
        end
    end

    // The read of mem in the next-state logic sees pre-edge contents, so a
    // write to the step firing on the same edge lands on its next visit.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the pattern is cleared by reset, so this stays a register
        // array rather than a RAM macro; it is only 64 bits.
        if (!resetn) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (pattern_we) begin
            mem[pattern_addr] <= pattern_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q <= '0;
            en    <= 1'b0;
        end else begin
            en <= (div_q == DIV_LAST);
            if (div_q == DIV_LAST) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drum_sequencer.sv
// Scoreboard bench for drum_sequencer: a step-timeline reference model queues
// the expected outputs per edge; a monitor pops and compares after each edge.
module tb_drum_sequencer;

    localparam int TB_DIV = 100;
    localparam int MIN_P  = 2;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [23:0] step_period;
    logic [3:0]  mute;
    logic        pattern_we;
    logic [3:0]  pattern_addr;
    logic [3:0]  pattern_wdata;
    logic [3:0]  go;
    logic        en;
    logic [3:0]  step;
    logic        playing;

    drum_sequencer #(
        .SAMPLE_DIV(TB_DIV),
        .MIN_PERIOD(MIN_P)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .run          (run),
        .step_period  (step_period),
        .mute         (mute),
        .pattern_we   (pattern_we),
        .pattern_addr (pattern_addr),
        .pattern_wdata(pattern_wdata),
        .go           (go),
        .en           (en),
        .step         (step),
        .playing      (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] go_v;
        logic [3:0] step_v;
        logic       playing_v;
        logic       en_v;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int en_cnt   = 0;

    // Reference model: absolute edge numbers, the edge of the next boundary,
    // and the pattern as a plain array.
    int         m_cyc  = 0;
    int         m_bd   = 0;
    int         m_step = 0;
    bit         m_play = 0;
    int         edges  = 0;
    logic [3:0] m_pat [16];
    logic [3:0] last_go;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_play = 0;
        m_step = 0;
        edges  = 0;
        for (int i = 0; i < 16; i++) m_pat[i] = 4'h0;
    endtask

    // Called at a negedge with inputs already set: predicts the edge, queues
    // the expectation, then advances to the following negedge.
    task automatic clock_edge();
        exp_t e;
        int   sp_eff;
        sp_eff = (int'(step_period) < MIN_P) ? MIN_P : int'(step_period);
        e.go_v = 4'h0;
        if (!run) begin
            m_play = 0;
            m_step = 0;
        end else if (!m_play) begin
            m_play = 1;
            m_step = 0;
            m_bd   = m_cyc + sp_eff;
            e.go_v = m_pat[0] & ~mute;
        end else if (m_cyc == m_bd) begin
            m_step = (m_step + 1) % 16;
            m_bd   = m_cyc + sp_eff;
            e.go_v = m_pat[m_step] & ~mute;
        end
        if (pattern_we) m_pat[pattern_addr] = pattern_wdata;
        m_cyc++;
        edges++;
        e.step_v    = m_step[3:0];
        e.playing_v = m_play;
        e.en_v      = (edges % TB_DIV == 0);
        last_go     = e.go_v;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_pat(input logic [3:0] a, input logic [3:0] d);
        pattern_we    = 1'b1;
        pattern_addr  = a;
        pattern_wdata = d;
        clock_edge();
        pattern_we    = 1'b0;
    endtask

    // Monitor: one expectation per clocked edge, compared 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (en === 1'b1) en_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("go", 32'(go), 32'(e.go_v));
                check("step", 32'(step), 32'(e.step_v));
                check("playing", 32'(playing), 32'(e.playing_v));
                check("en", 32'(en), 32'(e.en_v));
            end
        end
    end

    initial begin
        resetn        = 1'b0;
        run           = 1'b0;
        step_period   = 24'd0;
        mute          = 4'h0;
        pattern_we    = 1'b0;
        pattern_addr  = 4'h0;
        pattern_wdata = 4'h0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_go", 32'(go), 32'd0);
        check("reset_en", 32'(en), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        check("reset_playing", 32'(playing), 32'd0);
        resetn = 1'b1;
        model_reset();

        // Pattern and play: kick on step 0, cymbal on step 4, period 10.
        write_pat(4'd0, 4'b0001);
        write_pat(4'd4, 4'b1000);
        step_period = 24'd10;
        run = 1'b1;
        repeat (330) clock_edge();
        run = 1'b0;
        clock_edge();

        // Wrap and clamp: every step hi-hat, period 0 clamps to 2.
        for (int i = 0; i < 16; i++) write_pat(4'(i), 4'b0100);
        step_period = 24'd0;
        run = 1'b1;
        repeat (40) clock_edge();
        run = 1'b0;
        clock_edge();

        // Period change mid-step, then kick muted on step 1.
        for (int i = 0; i < 16; i++) write_pat(4'(i), 4'b0000);
        write_pat(4'd1, 4'b0001);
        write_pat(4'd2, 4'b0011);
        step_period = 24'd10;
        run = 1'b1;
        repeat (5) clock_edge();
        step_period = 24'd20;
        repeat (3) clock_edge();
        mute = 4'b0001;
        repeat (60) clock_edge();
        run  = 1'b0;
        mute = 4'h0;
        clock_edge();

        // Stop for one cycle mid-step, restart, then same-edge writes.
        for (int i = 0; i < 16; i++) write_pat(4'(i), 4'($urandom_range(0, 15)));
        step_period = 24'd7;
        run = 1'b1;
        repeat (17) clock_edge();
        run = 1'b0;
        clock_edge();
        run = 1'b1;
        repeat (20) clock_edge();
        step_period = 24'd3;
        repeat (80) begin
            if (m_play && m_cyc == m_bd) begin
                pattern_we    = 1'b1;
                pattern_addr  = 4'((m_step + 1) % 16);
                pattern_wdata = ~m_pat[(m_step + 1) % 16];
            end
            clock_edge();
            pattern_we = 1'b0;
        end

        // Randomized play.
        repeat (2000) begin
            run = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 15) == 0) step_period = 24'($urandom_range(0, 9));
            if ($urandom_range(0, 31) == 0) mute = 4'($urandom_range(0, 15));
            pattern_we    = ($urandom_range(0, 3) == 0);
            pattern_addr  = 4'($urandom_range(0, 15));
            pattern_wdata = 4'($urandom_range(0, 15));
            clock_edge();
        end
        pattern_we = 1'b0;
        run = 1'b0;
        mute = 4'h0;
        clock_edge();

        // Reset while a pulse is on go, then count en pulses.
        for (int i = 0; i < 16; i++) write_pat(4'(i), 4'hF);
        step_period = 24'd2;
        run = 1'b1;
        clock_edge();
        for (int i = 0; i < 4 && last_go == 4'h0; i++) clock_edge();
        check("pre_reset_go", 32'(go), 32'hF);
        resetn = 1'b0;
        #1;
        check("async_go", 32'(go), 32'd0);
        check("async_en", 32'(en), 32'd0);
        check("async_step", 32'(step), 32'd0);
        check("async_playing", 32'(playing), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        en_cnt = 0;
        step_period = 24'd3;
        repeat (20) clock_edge();
        run = 1'b0;
        repeat (10 * TB_DIV - 20) clock_edge();
        check("en_count", 32'(en_cnt), 32'd10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/drum_sequencer.md
# drum_sequencer

Step-pattern beat sequencer that drives the per-instrument sample playback counters. Holds a writable 16-step × 4-instrument pattern, advances one step every `step_period` clocks while `run` is high, and emits one-cycle `go` pulses (kick, snare, hi-hat, cymbal) that restart the matching counter. It also generates the free-running sample-rate enable `en` that those counters use to advance.

## Interface
- `SAMPLE_DIV`, default 1042: clocks per sample tick (50 MHz / 48 kHz).
- `MIN_PERIOD`, default 2: smallest honoured step period, in clocks.
- `clk`  in  1: system clock, rising edge.
- `resetn`  in  1: reset. Asynchronous, active-low.
- `run`  in  1: level; high = play, low = stop.
- `step_period`  in  24: clocks per step. Sampled only at start and at each step boundary.
- `mute`  in  4: per-instrument mask. A bit at 1 forces the matching `go` bit to 0.
- `pattern_we`  in  1: pattern write strobe.
- `pattern_addr`  in  4: step index to write.
- `pattern_wdata`  in  4: instrument bits for that step. Bit 0 kick, 1 snare, 2 hi-hat, 3 cymbal.
- `go`  out  4: one-cycle trigger pulses, one bit per instrument.
- `en`  out  1: sample tick, one cycle high every `SAMPLE_DIV` clocks.
- `step`  out  4: index of the step most recently fired.
- `playing`  out  1: high while in PLAY.

## Operation
- Reset (`resetn` low, asynchronous) clears the following, held until `resetn` rises:
  - state to IDLE;
  - `go`, `en`, `step`, `playing` to 0;
  - all pattern entries, the divider count, the step count and the latched period to 0.
- Sample divider:
  - `div` counts 0..`SAMPLE_DIV`-1 and wraps; it runs every cycle regardless of `run`.
  - `en` is registered and goes high in the cycle after `div` equals `SAMPLE_DIV`-1.
- Pattern memory:
  - 16 × 4 registers. When `pattern_we` is high at an edge, `mem[pattern_addr]` takes `pattern_wdata`.
  - Read-before-write: a write to the step fired at the same edge does not affect that edge's `go`. It takes effect on the next visit to that step.
- Period latch: `per_q` = max(`step_period`, `MIN_PERIOD`), captured at start and at every step boundary.
- IDLE:
  - `go`=0, `playing`=0, step count `scnt`=0.
  - `run` high at an edge: go to PLAY, `step`<=0, `scnt`<=0, latch `per_q`, `go`<=`mem[0]` & ~`mute`, `playing`<=1.
- PLAY:
  - `scnt` increments by 1 each cycle.
  - When `scnt` == `per_q`-1: `scnt`<=0, `step`<=`step`+1 (15 wraps to 0), `go`<=`mem[step+1]` & ~`mute`, latch `per_q`.
  - Otherwise `go`<=0.
  - `run` low at an edge takes priority over a boundary: go to IDLE, `go`<=0, `step`<=0, `playing`<=0, `scnt`<=0.
- `mute` is applied at the edge the pulse is generated; a pulse already on `go` is not cut short.
- `step_period` changes mid-step have no effect until the next boundary.

## Timing
- Start latency: `run` first sampled high at edge k → `go`=`mem[0]` and `playing`=1 during cycle k..k+1.
- Step spacing: consecutive step pulses are exactly `per_q` clocks apart (rising edge to rising edge).
- `go` bits are never high for two consecutive cycles, because `per_q` ≥ 2.
- Stop latency: `run` sampled low at edge k → `playing`=0 and `go`=0 after edge k.
- Restart: `run` high again at the next edge fires step 0 again. No extra idle cycle is required.
- `en` period is exactly `SAMPLE_DIV` clocks. Its first pulse after reset release occurs `SAMPLE_DIV` clocks after the first active edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Pattern and play:
  - Stimulus: write mem[0]=4'b0001, mem[4]=4'b1000, rest 0; `step_period`=10; raise `run`.
  - Required: `go`=0001 one cycle after `run`, then `go`=1000 exactly 40 clocks later, repeating every 160 clocks.
- Wrap and period clamp:
  - Stimulus: all steps =4'b0100; `step_period`=0.
  - Required: `go[2]` pulses every 2 clocks; `step` runs 0..15 then 0.
- Period change and mute:
  - Stimulus: `step_period` 10→20 mid-step; set `mute`=4'b0001 with mem[1]=0001.
  - Required: current step still lasts 10 clocks and the next lasts 20; step 1 produces `go`=0.
- Stop/restart and same-step write:
  - Stimulus: drop `run` for 1 cycle mid-step, then raise it; separately write mem[step+1] on its boundary edge.
  - Required: `playing` drops, then step 0 fires again; the boundary pulse uses the old data.
- Reset and sample tick:
  - Stimulus: assert `resetn`=0 mid-PLAY, then release; count `en` pulses over 10·`SAMPLE_DIV` clocks.
  - Required: all outputs 0 immediately and the pattern cleared; exactly 10 `en` pulses, each 1 cycle wide.
